jk_register_bank: RTL

//  WIDTH-bit register built from edge-triggered master-slave JK cells, one per bit.

---
 rtl/jk_bank_pkg.sv | 20 ++
 rtl/jk_cell.sv | 37 +++
 rtl/jk_register_bank.sv | 114 +++++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared encodings for the JK register bank and its cells.
package jk_bank_pkg;

  // Operating modes of the bank.
  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  // {J,K} pair meaning for a single cell.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_e;

endpackage

// File: rtl/jk_cell.sv
// Single-bit edge-triggered JK flip-flop with a per-instance reset value.
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic C,
  input  logic RESETn,
  input  logic RST_VAL,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qn
);

  logic q_q, q_d;

  // Next state from the JK truth table.
  always_comb begin
    q_d = q_q;
    case (jk_e'({J, K}))
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
    endcase
  end

  // State flop; reset is sampled on the clock edge only.
  always_ff @(posedge C) begin
    if (!RESETn) q_q <= RST_VAL;
    else         q_q <= q_d;
  end

  // Qn comes from the same flop, so it can never skew from Q.
  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit register of JK cells with JK, load, modulo count and shift modes.
// The bank only steers per-cell J/K; all state lives in the cells plus the OVF flop.
module jk_register_bank
  import jk_bank_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             C,
  input  logic             RESETn,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cell_j, cell_k;
  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] load_v, shift_v;
  logic             ovf_d, ovf_q;

  // Synchronous-counter toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & Q[i-1];
      dn_t[i] = dn_t[i-1] & ~Q[i-1];
    end
  end

  // Per-cell J/K steering and wrap detection; EN=0 holds every cell.
  always_comb begin
    cell_j  = '0;
    cell_k  = '0;
    ovf_d   = 1'b0;
    load_v  = (D > MAX_V) ? MAX_V : D;
    shift_v = {Q[WIDTH-2:0], SIN};
    if (EN) begin
      case (mode_e'(MODE))
        MODE_JK: begin
          cell_j = J;
          cell_k = K;
        end
        MODE_LOAD: begin
          cell_j = load_v;
          cell_k = ~load_v;
        end
        MODE_SHIFT: begin
          cell_j = shift_v;
          cell_k = ~shift_v;
        end
        MODE_COUNT: begin
          if (UP) begin
            if (Q >= MAX_V) begin
              // Wrap (or out-of-range value) forces every cell clear.
              cell_j = '0;
              cell_k = '1;
              ovf_d  = 1'b1;
            end else begin
              cell_j = up_t;
              cell_k = up_t;
            end
          end else begin
            if (Q == '0 || Q > MAX_V) begin
              // Both cases force MAX; only the underflow from zero is a wrap.
              cell_j = MAX_V;
              cell_k = ~MAX_V;
              ovf_d  = (Q == '0);
            end else begin
              cell_j = dn_t;
              cell_k = dn_t;
            end
          end
        end
      endcase
    end
  end

  // Overflow pulse flop, cleared by reset.
  always_ff @(posedge C) begin
    if (!RESETn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .C      (C),
      .RESETn (RESETn),
      .RST_VAL(RST_V[i]),
      .J      (cell_j[i]),
      .K      (cell_k[i]),
      .Q      (Q[i]),
      .Qn     (Qn[i])
    );
  end

  assign OVF = ovf_q;
  assign TC  = (MODE == MODE_COUNT) && (UP ? (Q == MAX_V) : (Q == '0));

endmodule
